pla_sweep_sequencer: RTL and testbench
======================================

# pla_sweep_sequencer

Upstream driver and result collector for a 9-input, single-output combinational PLA stage. On a start request it steps the PLA inputs through all 512 input vectors, one per cycle. It samples the PLA output each cycle and packs the 512 result bits into sixteen 32-bit words. Words are streamed out over a valid/ready interface with backpressure, so a characterisation memory or checker can consume the PLA's full truth table.

## Interface
Parameters:
- NUM_IN, 9: PLA input count; number of vectors = 2^NUM_IN = 512.
- WORD_W, 32: output word width; words per sweep = 512/WORD_W = 16.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  sampled in IDLE only; begins a sweep.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the final word handshake.
- pla_x  out  9  drives the PLA inputs; bit i drives input xi.
- pla_z  in  1  PLA output; combinational function of pla_x.
- out_valid  out  1  output word available.
- out_ready  in  1  consumer accepts the word when valid && ready.
- out_data  out  32  packed results; bit b of word w = f(vector 32w+b).
- out_index  out  4  word index w of out_data.
- ones_count  out  10  number of vectors with pla_z=1; present only with PLA_SWEEP_POPCOUNT_EN.

## Operation
- Reset (rst_n=0 at an edge) sets:
  - state=IDLE, pla_x=0, busy=0, done=0;
  - out_valid=0, out_data=0, out_index=0;
  - shift word=0, ones_count=0.
- States: IDLE, RUN, FLUSH.
  - IDLE: start=1 moves to RUN. ones_count clears on this transition.
  - RUN: vector counter vec (9 bits) drives pla_x directly.
    - Each advancing cycle, pla_z is written into shift-word bit vec[4:0] and vec increments.
    - When vec[4:0]==31 advances, the completed word (including this bit) loads into out_data, with out_index=vec[8:5] and out_valid=1.
    - After vec=511 advances, vec wraps to 0 and the state moves to FLUSH.
  - FLUSH: wait for the handshake on word 15, then return to IDLE with done=1 for one cycle.
- Stall: RUN does not advance (vec held, no sample, pla_x stable) when vec[4:0]==31, out_valid=1 and out_ready=0.
- Backpressure in other cycles never stops the sweep, because the shift word is separate from out_data.
- A handshake and a new-word load in the same cycle are allowed. The old word is consumed, the new word loads, out_valid stays 1, and no bubble is inserted.
- out_valid clears on a handshake with no simultaneous load. out_data holds its value after the handshake.
- start is ignored while busy. start held high continuously begins a new sweep in the cycle after done.
- Reset in the middle of a sweep discards the partial word and any pending out_valid word. done is not pulsed.

## Timing
- Let start be sampled at edge 0 and out_ready be held at 1.
- Cycles 1..512: RUN, with pla_x = cycle-1.
- Word w is valid in cycle 33+32w, so word 0 is valid in cycle 33 and word 15 in cycle 513.
- Word 15 is accepted in cycle 513. done=1 and busy=0 in cycle 514.
- Throughput is 1 vector/cycle. Each cycle of out_ready stall at a word boundary adds one cycle.
- pla_x is registered. The combinational path is pla_x → PLA → pla_z → capture flop within one cycle.

## Configuration
- PLA_SWEEP_POPCOUNT_EN defined: ones_count is present.
  - It is a 10-bit counter that increments on each advancing RUN cycle with pla_z=1.
  - It clears when a sweep starts and on reset, and holds its final value until the next start.
  - Its range is 0..512.
- PLA_SWEEP_POPCOUNT_EN undefined: neither the port nor the counter exists. All other behaviour is identical.

## Structure
- Package pla_sweep_pkg holds:
  - the state enum (IDLE, RUN, FLUSH);
  - NUM_VEC=512, WORD_W=32, NUM_WORDS=16;
  - the widths of vec and out_index.
- Sub-module pla_sweep_packer holds:
  - the shift word;
  - the out_data/out_index/out_valid register;
  - the stall logic, which outputs advance_ok.
- The top level holds the FSM, the vec counter and the optional popcount.

## Test plan
- Stub PLA z=x0, out_ready=1: 16 words all 0xAAAAAAAA, out_index 0..15 in order; done in cycle 514; ones_count=256.
- Stub z=x5: even-index words 0x00000000 and odd-index words 0xFFFFFFFF; ones_count=256.
- Stub z=1, out_ready=0 for 40 cycles after word 0 becomes valid:
  - the sweep stalls at vec=63;
  - word 0 is held unchanged;
  - after out_ready rises, words are all 0xFFFFFFFF, ones_count=512 and done is delayed accordingly.
- out_ready toggling 1/0 every cycle: no word is lost or duplicated, the index sequence is 0..15, and the data matches the reference truth table of the 9-input PLA under test.
- start pulsed again at cycle 200 during a sweep: ignored; exactly 16 words and one done pulse.
- rst_n=0 for one cycle at cycle 300: busy=0, out_valid=0 and pla_x=0 next cycle, with no done. A new start then produces a full, correct 16-word sweep.

Source files
------------

// File: rtl/pla_sweep_pkg.sv
// pla_sweep_pkg: shared types and constants for the PLA truth-table sweep
// sequencer (state encoding, vector/word geometry, counter widths).
// Ports: none (package).
package pla_sweep_pkg;

  localparam int NUM_IN    = 9;
  localparam int NUM_VEC   = 512;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = NUM_VEC / WORD_W;
  localparam int VEC_W     = NUM_IN;   // vector counter width
  localparam int IDX_W     = 4;        // out_index width
  localparam int BIT_W     = 5;        // bit position inside a word
  localparam int CNT_W     = 10;       // popcount width, holds 0..512

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/pla_sweep_packer.sv
// pla_sweep_packer: collects one PLA result bit per advancing cycle into a
// shift word and hands completed words to a valid/ready output register.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   run                sequencer is in its sweep state
//   bit_pos, word_idx  current vector split into bit-in-word / word index
//   pla_z              PLA output for the current vector
//   out_ready          consumer ready
//   advance_ok         0 when the sweep must hold (word boundary, output full)
//   out_valid/out_data/out_index  output word register
module pla_sweep_packer
  import pla_sweep_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [BIT_W-1:0]  bit_pos,
  input  logic [IDX_W-1:0]  word_idx,
  input  logic              pla_z,
  input  logic              out_ready,
  output logic              advance_ok,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index
);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  // The top bit of a word is never stored here: it goes straight from pla_z
  // into out_data on the load cycle.
  logic [WORD_W-2:0] shift_word;
  logic              at_last_bit;
  logic              sample;
  logic              load;
  logic              handshake;

  assign at_last_bit = (bit_pos == LAST_BIT);
  // Only a word boundary with an unconsumed output word blocks the sweep; a
  // same-cycle handshake frees the register for the new word.
  assign advance_ok  = !(at_last_bit && out_valid && !out_ready);
  assign sample      = run && advance_ok;
  assign load        = sample && at_last_bit;
  assign handshake   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_word <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
    end else begin
      if (sample && !at_last_bit)
        shift_word[bit_pos] <= pla_z;
      if (load) begin
        out_data  <= {pla_z, shift_word};
        out_index <= word_idx;
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pla_sweep_sequencer.sv
// pla_sweep_sequencer: steps a 9-input PLA through all 512 input vectors,
// one per cycle, and streams the 512 result bits out as sixteen 32-bit words
// over valid/ready with backpressure.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           begins a sweep (sampled in IDLE only)
//   busy            high whenever a sweep is in progress
//   done            one-cycle pulse after the last word is accepted
//   pla_x / pla_z   PLA input vector (registered) / PLA output
//   out_valid, out_ready, out_data, out_index   result word stream
//   ones_count      count of vectors with pla_z=1 (PLA_SWEEP_POPCOUNT_EN only)
// Build option: define PLA_SWEEP_POPCOUNT_EN to add the ones_count port.
//
// State table:
//   IDLE  | waiting for start, pla_x=0
//   RUN   | stepping vectors, sampling pla_z, packing words
//   FLUSH | all vectors sampled, waiting for word 15 to be accepted
module pla_sweep_sequencer #(
  parameter int NUM_IN = 9,
  parameter int WORD_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_IN-1:0]             pla_x,
  input  logic                          pla_z,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_W-1:0]             out_data,
  output logic [pla_sweep_pkg::IDX_W-1:0] out_index
`ifdef PLA_SWEEP_POPCOUNT_EN
  ,
  output logic [pla_sweep_pkg::CNT_W-1:0] ones_count
`endif
);

  import pla_sweep_pkg::*;

  localparam logic [VEC_W-1:0] LAST_VEC  = VEC_W'(NUM_VEC - 1);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(NUM_WORDS - 1);

  state_t           state;
  state_t           state_next;
  logic             done_next;
  logic [VEC_W-1:0] vec;
  logic             run;
  logic             advance_ok;
  logic             advance;

  assign run     = (state == RUN);
  assign advance = run && advance_ok;
  assign busy    = (state != IDLE);
  assign pla_x   = vec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      vec   <= '0;
    end else begin
      state <= state_next;
      done  <= done_next;
      // Wraps to 0 after the last vector, so pla_x rests at 0 outside RUN.
      if (advance)
        vec <= vec + VEC_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_next = RUN;
      end
      RUN: begin
        if (advance && (vec == LAST_VEC))
          state_next = FLUSH;
      end
      FLUSH: begin
        if (out_valid && out_ready && (out_index == LAST_WORD)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  pla_sweep_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .bit_pos    (vec[BIT_W-1:0]),
    .word_idx   (vec[VEC_W-1:BIT_W]),
    .pla_z      (pla_z),
    .out_ready  (out_ready),
    .advance_ok (advance_ok),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_index  (out_index)
  );

`ifdef PLA_SWEEP_POPCOUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      ones_count <= '0;
    else if ((state == IDLE) && start)
      ones_count <= '0;
    else if (advance && pla_z)
      ones_count <= ones_count + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_pla_sweep_sequencer.sv
// Testbench for pla_sweep_sequencer: a stub PLA backed by a 512-entry truth
// table, a word-level reference model computed from that table, and one
// compare process checking every accepted word, held words and done.
module tb_pla_sweep_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [8:0]  pla_x;
  logic        pla_z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_index;
`ifdef PLA_SWEEP_POPCOUNT_EN
  logic [9:0]  ones_count;
`endif

  always #5 clk = ~clk;

  pla_sweep_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pla_x      (pla_x),
    .pla_z      (pla_z),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index)
`ifdef PLA_SWEEP_POPCOUNT_EN
    ,
    .ones_count (ones_count)
`endif
  );

  logic tt [512];
  always_comb pla_z = tt[pla_x];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int w);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = tt[32 * w + b];
    return r;
  endfunction

  function automatic int model_ones();
    int n = 0;
    for (int i = 0; i < 512; i++) n += int'(tt[i]);
    return n;
  endfunction

  // compare process state
  logic        chk_en = 1'b0;
  int          exp_idx;
  int          done_cnt;
  logic [31:0] got [16];
  logic        prev_hold;
  logic [31:0] prev_data;
  logic [3:0]  prev_idx;

  always @(negedge clk) begin
    if (chk_en) begin
      if (prev_hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, prev_data);
        chk("hold_index", 32'(out_index), 32'(prev_idx));
      end
      if (out_valid && out_ready) begin
        if (exp_idx < 16) begin
          chk("word_index", 32'(out_index), 32'(exp_idx));
          chk("word_data", out_data, model_word(exp_idx));
          got[exp_idx] = out_data;
        end else begin
          checks++;
          failures++;
          $display("FAIL extra_word actual_index=%0d expected_no_word", out_index);
        end
        exp_idx++;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_idx  = out_index;
      if (done) begin
        done_cnt++;
        chk("done_word_count", 32'(exp_idx), 32'd16);
`ifdef PLA_SWEEP_POPCOUNT_EN
        chk("done_ones_count", 32'(ones_count), 32'(model_ones()));
`endif
      end
    end
  end

  // mode: 0 z=x0, 1 z=x5, 2 z=1, 3 random table
  // rmode: 0 ready=1, 1 toggling, 2 low for 40 cycles from cycle 33
  task automatic run_sweep(input int mode, input int rmode, input int restart_at,
                           input int rst_at, output int done_cyc);
    logic saw_done = 1'b0;
    for (int i = 0; i < 512; i++) begin
      case (mode)
        0:       tt[i] = 1'(i & 1);
        1:       tt[i] = 1'((i >> 5) & 1);
        2:       tt[i] = 1'b1;
        default: tt[i] = 1'($urandom & 1);
      endcase
    end
    for (int w = 0; w < 16; w++) got[w] = 32'hDEADBEEF;
    exp_idx   = 0;
    done_cnt  = 0;
    prev_hold = 1'b0;
    done_cyc  = -1;
    @(posedge clk); #1;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);   // edge 0: start sampled
    chk_en = 1'b1;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      #1;
      start = (cyc == restart_at);
      case (rmode)
        1:       out_ready = (cyc % 2 == 1);
        2:       out_ready = !(cyc >= 33 && cyc < 73);
        default: out_ready = 1'b1;
      endcase
      rst_n = !(cyc == rst_at);
      if (rst_at > 0 && cyc == rst_at + 1) chk_en = 1'b0;
      @(negedge clk);
      if (rmode == 0 && rst_at < 0 && mode != 3 && (cyc == 1 || cyc == 100 || cyc == 512))
        chk("pla_x_seq", 32'(pla_x), 32'(cyc - 1));
      if (rmode == 2 && cyc == 70) begin
        chk("stall_pla_x", 32'(pla_x), 32'd63);
        chk("stall_word0_data", out_data, 32'hFFFFFFFF);
        chk("stall_word0_index", 32'(out_index), 32'd0);
        chk("stall_word0_valid", 32'(out_valid), 32'd1);
      end
      if (rst_at > 0 && cyc == rst_at + 1) begin
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pla_x", 32'(pla_x), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
      end
      if (done) saw_done = 1'b1;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (rst_at > 0 && cyc == rst_at + 6) break;
      if (done_cyc > 0 && cyc >= done_cyc + 3) break;
      @(posedge clk);
    end
    chk_en = 1'b0;
    if (rst_at < 0) begin
      chk("done_seen", 32'(done_cyc > 0), 32'd1);
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("busy_after_done", 32'(busy), 32'd0);
    end else begin
      chk("no_done_on_reset", 32'(saw_done), 32'd0);
    end
  endtask

  initial begin
    int dc;
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 512; i++) tt[i] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_index", 32'(out_index), 32'd0);
    chk("reset_pla_x", 32'(pla_x), 32'd0);
`ifdef PLA_SWEEP_POPCOUNT_EN
    chk("reset_ones_count", 32'(ones_count), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_sweep(0, 0, -1, -1, dc);
    chk("x0_done_cycle", 32'(dc), 32'd514);
    chk("x0_word0", got[0], 32'hAAAAAAAA);
    chk("x0_word15", got[15], 32'hAAAAAAAA);
`ifdef PLA_SWEEP_POPCOUNT_EN
    chk("x0_ones", 32'(ones_count), 32'd256);
`endif

    run_sweep(1, 0, -1, -1, dc);
    chk("x5_done_cycle", 32'(dc), 32'd514);
    chk("x5_word0", got[0], 32'h00000000);
    chk("x5_word1", got[1], 32'hFFFFFFFF);
    chk("x5_word14", got[14], 32'h00000000);
    chk("x5_word15", got[15], 32'hFFFFFFFF);
`ifdef PLA_SWEEP_POPCOUNT_EN
    chk("x5_ones", 32'(ones_count), 32'd256);
`endif

    run_sweep(2, 2, -1, -1, dc);
    chk("stall_done_cycle", 32'(dc), 32'd523);
    chk("stall_word0", got[0], 32'hFFFFFFFF);
    chk("stall_word15", got[15], 32'hFFFFFFFF);
`ifdef PLA_SWEEP_POPCOUNT_EN
    chk("stall_ones", 32'(ones_count), 32'd512);
`endif

    run_sweep(3, 1, -1, -1, dc);

    run_sweep(3, 0, 200, -1, dc);
    chk("restart_done_cycle", 32'(dc), 32'd514);

    run_sweep(3, 0, -1, 300, dc);
    run_sweep(3, 0, -1, -1, dc);
    chk("post_reset_done_cycle", 32'(dc), 32'd514);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
